csr_timer_int: RTL and testbench

- Parametrised timer/interrupt CSR slice for the LoongArch pipeline CSR subsystem.
- Owns ECFG.LIE, ESTAT.IS, TID, TCFG, TVAL and TICLR, plus the constant timer, hardware-interrupt sampling and IPI sampling.
- Produces has_int for the ID stage.
- Sits beside the main CSR file; the top level ORs csr_rvalue with the main file's read data. CRMD, PRMD, ERA, ECODE and the other CSRs stay in the main file.

---
 rtl/csr_timer_int.sv | 147 ++++++++++++++
 tb/tb_csr_timer_int.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_timer_int.sv
// Timer/interrupt CSR slice: ECFG.LIE, ESTAT.IS, TID/TCFG/TVAL/TICLR, has_int for ID.
// Latency: reads are combinational; writes, HWI/IPI sampling and timer fire land next cycle.
// Backpressure: none, a CSR access completes in the cycle it is presented. Optional CSR_TIMER_PRESCALE_EN.
module csr_timer_int #(
    parameter int          TIMER_W   = 32,
    parameter int          HW_INT_N  = 8,
    parameter logic [31:0] TID_RESET = 32'h0
`ifdef CSR_TIMER_PRESCALE_EN
    ,
    parameter int          PRESCALE  = 4
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                csr_re,
    input  logic [13:0]         csr_num,
    output logic [31:0]         csr_rvalue,
    input  logic                csr_we,
    input  logic [31:0]         csr_wmask,
    input  logic [31:0]         csr_wvalue,
    input  logic [HW_INT_N-1:0] hw_int_in,
    input  logic                ipi_int_in,
    input  logic                crmd_ie,
    output logic [12:0]         estat_is,
    output logic                timer_int,
    output logic                has_int
);

    localparam logic [13:0] CSR_ECFG  = 14'h04;
    localparam logic [13:0] CSR_ESTAT = 14'h05;
    localparam logic [13:0] CSR_TID   = 14'h40;
    localparam logic [13:0] CSR_TCFG  = 14'h41;
    localparam logic [13:0] CSR_TVAL  = 14'h42;
    localparam logic [13:0] CSR_TICLR = 14'h44;
    localparam logic [12:0] LIE_MASK  = 13'h1bff;

    logic [12:0]          lie;
    logic [1:0]           is_sw;
    logic [HW_INT_N-1:0]  is_hw;
    logic                 is_ti;
    logic                 is_ipi;
    logic [31:0]          tid;
    logic [TIMER_W-1:0]   tcfg;
    logic [TIMER_W-1:0]   counter;
    logic                 armed;

    logic wr_ecfg, wr_estat, wr_tid, wr_tcfg, wr_ticlr;
    logic tick, fire;
    logic [TIMER_W-1:0] tcfg_new;
    logic [TIMER_W-1:0] reload_val;

    assign wr_ecfg  = csr_we && (csr_num == CSR_ECFG);
    assign wr_estat = csr_we && (csr_num == CSR_ESTAT);
    assign wr_tid   = csr_we && (csr_num == CSR_TID);
    assign wr_tcfg  = csr_we && (csr_num == CSR_TCFG);
    assign wr_ticlr = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];

    assign tcfg_new   = (csr_wmask[TIMER_W-1:0] & csr_wvalue[TIMER_W-1:0])
                      | (~csr_wmask[TIMER_W-1:0] & tcfg);
    assign reload_val = {tcfg[TIMER_W-1:2], 2'b00};

`ifdef CSR_TIMER_PRESCALE_EN
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
    logic [PW-1:0] pre_cnt;

    assign tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      pre_cnt <= '0;
        else if (wr_tcfg) pre_cnt <= '0;
        else if (tick)    pre_cnt <= '0;
        else              pre_cnt <= pre_cnt + PW'(1);
    end
`else
    assign tick = 1'b1;
`endif

    // A TCFG write in the same cycle as counter==0 suppresses the fire.
    assign fire = armed && tick && !wr_tcfg && (counter == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lie     <= '0;
            is_sw   <= '0;
            is_hw   <= '0;
            is_ti   <= 1'b0;
            is_ipi  <= 1'b0;
            tid     <= TID_RESET;
            tcfg    <= '0;
            counter <= '0;
            armed   <= 1'b0;
        end else begin
            is_hw  <= hw_int_in;
            is_ipi <= ipi_int_in;
            if (wr_ecfg)
                lie <= ((csr_wmask[12:0] & csr_wvalue[12:0]) | (~csr_wmask[12:0] & lie)) & LIE_MASK;
            if (wr_estat)
                is_sw <= (csr_wmask[1:0] & csr_wvalue[1:0]) | (~csr_wmask[1:0] & is_sw);
            if (wr_tid)
                tid <= (csr_wmask & csr_wvalue) | (~csr_wmask & tid);

            if (wr_tcfg) begin
                tcfg    <= tcfg_new;
                counter <= {tcfg_new[TIMER_W-1:2], 2'b00};
                armed   <= tcfg_new[0];
            end else if (armed && tick) begin
                if (counter != '0)
                    counter <= counter - TIMER_W'(1);
                else if (tcfg[1])
                    counter <= reload_val;
                else
                    armed <= 1'b0;
            end

            // Fire has priority over a same-cycle TICLR clear.
            if (fire)          is_ti <= 1'b1;
            else if (wr_ticlr) is_ti <= 1'b0;
        end
    end

    always_comb begin
        estat_is = '0;
        estat_is[1:0] = is_sw;
        estat_is[2 +: HW_INT_N] = is_hw;
        estat_is[11] = is_ti;
        estat_is[12] = is_ipi;
    end

    assign timer_int = is_ti;
    assign has_int   = crmd_ie & (|(estat_is & lie));

    always_comb begin
        csr_rvalue = '0;
        if (csr_re) begin
            case (csr_num)
                CSR_ECFG:  csr_rvalue[12:0] = lie;
                CSR_ESTAT: csr_rvalue[12:0] = estat_is;
                CSR_TID:   csr_rvalue = tid;
                CSR_TCFG:  csr_rvalue[TIMER_W-1:0] = tcfg;
                CSR_TVAL:  csr_rvalue[TIMER_W-1:0] = counter;
                default:   csr_rvalue = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_timer_int.sv
// Directed bench for csr_timer_int: table-driven CSR reads/writes plus timer and interrupt sequences.
module tb_csr_timer_int;

    localparam logic [13:0] ECFG  = 14'h04;
    localparam logic [13:0] ESTAT = 14'h05;
    localparam logic [13:0] TID   = 14'h40;
    localparam logic [13:0] TCFG  = 14'h41;
    localparam logic [13:0] TVAL  = 14'h42;
    localparam logic [13:0] TICLR = 14'h44;
`ifdef CSR_TIMER_PRESCALE_EN
    localparam int PS = 4;
`else
    localparam int PS = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_rvalue;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        crmd_ie;
    logic [12:0] estat_is;
    logic        timer_int;
    logic        has_int;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    csr_timer_int dut (
        .clk        (clk),
        .resetn     (resetn),
        .csr_re     (csr_re),
        .csr_num    (csr_num),
        .csr_rvalue (csr_rvalue),
        .csr_we     (csr_we),
        .csr_wmask  (csr_wmask),
        .csr_wvalue (csr_wvalue),
        .hw_int_in  (hw_int_in),
        .ipi_int_in (ipi_int_in),
        .crmd_ie    (crmd_ie),
        .estat_is   (estat_is),
        .timer_int  (timer_int),
        .has_int    (has_int)
    );

    typedef struct {
        logic        re;
        logic [13:0] num;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [13:0] num;
        logic [31:0] mask;
        logic [31:0] val;
        logic [13:0] rnum;
        logic [31:0] exp;
    } wr_vec_t;

    rd_vec_t rv[8];
    wr_vec_t wv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v;
        cyc();
        csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    endtask

    task automatic rd(input string name, input logic [13:0] n, input logic [31:0] exp);
        csr_re = 1'b1; csr_num = n;
        #1;
        chk(name, csr_rvalue, exp);
        csr_re = 1'b0;
    endtask

    initial begin
        logic refire;
        resetn = 1'b0; csr_re = 1'b0; csr_num = '0; csr_we = 1'b0;
        csr_wmask = '0; csr_wvalue = '0; hw_int_in = '0; ipi_int_in = 1'b0; crmd_ie = 1'b0;

        rv[0] = '{1'b1, ECFG,  32'h0};
        rv[1] = '{1'b1, ESTAT, 32'h0};
        rv[2] = '{1'b1, TID,   32'h0};
        rv[3] = '{1'b1, TCFG,  32'h0};
        rv[4] = '{1'b1, TVAL,  32'h0};
        rv[5] = '{1'b1, TICLR, 32'h0};
        rv[6] = '{1'b1, 14'h00, 32'h0};
        rv[7] = '{1'b0, TID,   32'h0};

        wv[0]  = '{ECFG,  32'hffffffff, 32'h00001fff, ECFG,  32'h00001bff};
        wv[1]  = '{ECFG,  32'h0000000f, 32'h00000000, ECFG,  32'h00001bf0};
        wv[2]  = '{ECFG,  32'hffffffff, 32'h00000000, ECFG,  32'h00000000};
        wv[3]  = '{TID,   32'h0000ffff, 32'h12345678, TID,   32'h00005678};
        wv[4]  = '{TID,   32'hffff0000, 32'habcdffff, TID,   32'habcd5678};
        wv[5]  = '{ESTAT, 32'hffffffff, 32'hffffffff, ESTAT, 32'h00000003};
        wv[6]  = '{ESTAT, 32'h00000001, 32'h00000000, ESTAT, 32'h00000002};
        wv[7]  = '{ESTAT, 32'hffffffff, 32'h00000000, ESTAT, 32'h00000000};
        wv[8]  = '{TICLR, 32'hffffffff, 32'hffffffff, TICLR, 32'h00000000};
        wv[9]  = '{TCFG,  32'h0000ffff, 32'h00012340, TCFG,  32'h00002340};
        wv[10] = '{TVAL,  32'hffffffff, 32'h00000055, TVAL,  32'h00002340};
        wv[11] = '{TCFG,  32'hffffffff, 32'h00000000, TVAL,  32'h00000000};

        #12;
        resetn = 1'b1;
        cyc();

        // Reset state
        for (int i = 0; i < 8; i++) begin
            csr_re = rv[i].re; csr_num = rv[i].num;
            #1;
            chk($sformatf("reset_rd[%0d]", i), csr_rvalue, rv[i].exp);
        end
        csr_re = 1'b0;
        chk("reset_has_int", {31'b0, has_int}, 32'h0);
        chk("reset_estat_is", {19'b0, estat_is}, 32'h0);

        // Masked writes and readback
        for (int i = 0; i < 12; i++) begin
            wr(wv[i].num, wv[i].mask, wv[i].val);
            rd($sformatf("wr_vec[%0d]", i), wv[i].rnum, wv[i].exp);
        end

        // Periodic timer: InitVal=2 -> counts 8..0, fires, reloads 8
        wr(TCFG, 32'hffffffff, 32'h0000000b);
        for (int v = 8; v >= 0; v--) begin
            for (int k = 0; k < PS; k++) begin
                rd($sformatf("per_tval_%0d", v), TVAL, 32'(v));
                chk("per_no_fire_yet", {31'b0, timer_int}, 32'h0);
                cyc();
            end
        end
        rd("per_reload", TVAL, 32'h8);
        chk("per_fire", {31'b0, timer_int}, 32'h1);
        rd("per_estat_ti", ESTAT, 32'h00000800);

        wr(TCFG, 32'hffffffff, 32'h0);
        rd("disarm_tval", TVAL, 32'h0);
        wr(TICLR, 32'hffffffff, 32'h1);
        chk("ticlr_clear", {31'b0, timer_int}, 32'h0);

        // One-shot: InitVal=4 -> 16 cycles down, one fire, hold 0
        wr(TCFG, 32'hffffffff, 32'h00000011);
        cyc(17 * PS - 1);
        chk("os_before_fire", {31'b0, timer_int}, 32'h0);
        rd("os_tval_zero", TVAL, 32'h0);
        cyc();
        chk("os_fire", {31'b0, timer_int}, 32'h1);
        rd("os_tval_hold", TVAL, 32'h0);
        wr(TICLR, 32'h00000001, 32'h1);
        chk("os_clear", {31'b0, timer_int}, 32'h0);
        refire = 1'b0;
        repeat (50) begin
            cyc();
            if (timer_int) refire = 1'b1;
        end
        chk("os_no_refire", {31'b0, refire}, 32'h0);
        rd("os_tval_after", TVAL, 32'h0);

        // Fire and TICLR clear in the same cycle: fire wins
        wr(TCFG, 32'hffffffff, 32'h00000003);
        cyc(2 * PS - 1);
        wr(TICLR, 32'hffffffff, 32'h1);
        chk("collide_fire_wins", {31'b0, timer_int}, 32'h1);
        wr(TCFG, 32'hffffffff, 32'h0);
        wr(TICLR, 32'hffffffff, 32'h1);
        chk("collide_cleared", {31'b0, timer_int}, 32'h0);

        // TCFG write on the counter==0 cycle: write wins, reload, no fire
        wr(TCFG, 32'hffffffff, 32'h00000001);
        cyc(PS - 1);
        wr(TCFG, 32'hffffffff, 32'h00000005);
        chk("wr_wins_no_fire", {31'b0, timer_int}, 32'h0);
        rd("wr_wins_reload", TVAL, 32'h4);
        wr(TCFG, 32'hffffffff, 32'h0);

        // Interrupt gating
        wr(TCFG, 32'hffffffff, 32'h00000001);
        cyc(PS);
        chk("gate_ti_set", {19'b0, estat_is}, 32'h00000800);
        wr(ECFG, 32'hffffffff, 32'h00000800);
        crmd_ie = 1'b1; #1;
        chk("gate_has_int_ti", {31'b0, has_int}, 32'h1);
        crmd_ie = 1'b0; #1;
        chk("gate_ie_off", {31'b0, has_int}, 32'h0);
        crmd_ie = 1'b1;
        wr(ECFG, 32'hffffffff, 32'h00000004);
        chk("gate_lie_masks_ti", {31'b0, has_int}, 32'h0);
        hw_int_in = 8'h01; #1;
        chk("hwi_latency", {31'b0, estat_is[2]}, 32'h0);
        cyc();
        chk("hwi_sampled", {19'b0, estat_is}, 32'h00000804);
        chk("gate_has_int_hwi", {31'b0, has_int}, 32'h1);
        wr(ESTAT, 32'h00000003, 32'h00000002);
        rd("estat_sw1", ESTAT, 32'h00000806);
        ipi_int_in = 1'b1;
        cyc();
        chk("ipi_sampled", {19'b0, estat_is}, 32'h00001806);
        hw_int_in = 8'h00; ipi_int_in = 1'b0;
        cyc();
        chk("hwi_ipi_drop", {19'b0, estat_is}, 32'h00000802);

        // Async reset mid-count
        wr(TICLR, 32'hffffffff, 32'h1);
        wr(ECFG, 32'hffffffff, 32'h00000800);
        wr(TCFG, 32'hffffffff, 32'h0000000b);
        cyc(12 * PS);
        chk("ar_pre_has_int", {31'b0, has_int}, 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        rd("ar_tval", TVAL, 32'h0);
        chk("ar_estat_is", {19'b0, estat_is}, 32'h0);
        chk("ar_has_int", {31'b0, has_int}, 32'h0);
        chk("ar_timer_int", {31'b0, timer_int}, 32'h0);
        rd("ar_tid", TID, 32'h0);
        #2;
        resetn = 1'b1;
        cyc(20 * PS);
        rd("ar_post_tval", TVAL, 32'h0);
        chk("ar_post_no_fire", {31'b0, timer_int}, 32'h0);
        chk("ar_post_has_int", {31'b0, has_int}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
